llsc_ctrl: RTL and testbench



---
 rtl/llsc_ctrl_pkg.sv | 13 +
 rtl/llsc_ctrl.sv | 132 +++++++++++++
 tb/tb_llsc_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/llsc_ctrl_pkg.sv
// Shared definitions for the LL/SC controller: widths and FSM state encoding.
package llsc_ctrl_pkg;

  localparam int unsigned LLSC_ADDR_W = 32;
  localparam int unsigned LLSC_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } llsc_state_e;

endpackage : llsc_ctrl_pkg

// File: rtl/llsc_ctrl.sv
// LL.W / SC.W controller: owns LLbit, issues successful SC.W stores to the
// data-cache port and returns the one-cycle SC.W completion to the pipeline.
module llsc_ctrl
  import llsc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = LLSC_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ll_commit,
  input  logic                   ertn_commit,
  input  logic                   llbctl_klo,
  input  logic                   llbctl_wcllb,
  input  logic                   sc_req_valid,
  output logic                   sc_req_ready,
  input  logic [ADDR_W-1:0]      sc_paddr,
  input  logic [LLSC_DATA_W-1:0] sc_wdata,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LLSC_DATA_W-1:0] mem_wdata,
  output logic                   sc_resp_valid,
  output logic                   sc_resp_result,
  output logic                   llbit,
  output logic                   klo_clear
);

  llsc_state_e            state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   flushed_q, flushed_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LLSC_DATA_W-1:0] wdata_q, wdata_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   result_q, result_d;
  logic                   llbit_q, llbit_d;
  logic                   klo_clear_q, klo_clear_d;
  logic                   sc_ok;
  logic                   llbit_clr;

  // Next-state, store-port and LLbit logic.
  always_comb begin
    state_d      = state_q;
    flushed_d    = flushed_q;
    mem_req_d    = mem_req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    result_d     = result_q;
    sc_ok        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A flushed request is never accepted; LLbit is sampled only here.
        if (sc_req_valid && !flush) begin
          if (llbit_q) begin
            state_d   = ST_ISSUE;
            mem_req_d = 1'b1;
            addr_d    = sc_paddr;
            wdata_d   = sc_wdata;
            flushed_d = 1'b0;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            result_d     = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        // The store cannot be recalled once issued; a flush only hides the reply.
        if (flush) flushed_d = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          sc_ok     = 1'b1;
          if (flushed_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            result_d     = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_IDLE);
    llbit_clr   = llbctl_wcllb || (ertn_commit && !llbctl_klo) || sc_ok;
    llbit_d     = llbit_clr ? 1'b0 : (ll_commit ? 1'b1 : llbit_q);
    klo_clear_d = ertn_commit && llbctl_klo;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      flushed_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= 1'b0;
      llbit_q      <= 1'b0;
      klo_clear_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      flushed_q    <= flushed_d;
      mem_req_q    <= mem_req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      llbit_q      <= llbit_d;
      klo_clear_q  <= klo_clear_d;
    end
  end

  assign sc_req_ready   = ready_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  // A flush arriving in the response cycle kills the writeback immediately.
  assign sc_resp_valid  = resp_valid_q && !flush;
  assign sc_resp_result = result_q;
  assign llbit          = llbit_q;
  assign klo_clear      = klo_clear_q;

endmodule : llsc_ctrl

// File: tb/tb_llsc_ctrl.sv
// Directed bench for llsc_ctrl: vector table plus hand-written corner sequences.
module tb_llsc_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, ll_commit, ertn_commit, llbctl_klo, llbctl_wcllb;
  logic        sc_req_valid, sc_req_ready, mem_req, mem_ack;
  logic [31:0] sc_paddr, sc_wdata, mem_addr, mem_wdata;
  logic        sc_resp_valid, sc_resp_result, llbit, klo_clear;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  llsc_ctrl #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ll_commit     (ll_commit),
    .ertn_commit   (ertn_commit),
    .llbctl_klo    (llbctl_klo),
    .llbctl_wcllb  (llbctl_wcllb),
    .sc_req_valid  (sc_req_valid),
    .sc_req_ready  (sc_req_ready),
    .sc_paddr      (sc_paddr),
    .sc_wdata      (sc_wdata),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .sc_resp_valid (sc_resp_valid),
    .sc_resp_result(sc_resp_result),
    .llbit         (llbit),
    .klo_clear     (klo_clear)
  );

  typedef struct {
    string       name;
    logic        rst, flush, ll, ertn, klo, wcllb, scv, ack;
    logic [31:0] addr, wdata;
    logic        e_ready, e_req, e_rv, e_res, e_llb, e_klo;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; ll_commit = 0; ertn_commit = 0; llbctl_klo = 0;
    llbctl_wcllb = 0; sc_req_valid = 0; mem_ack = 0; sc_paddr = '0; sc_wdata = '0;
  endtask

  task automatic add(input string n,
                     input logic r, input logic f, input logic l, input logic e,
                     input logic k, input logic w, input logic s, input logic a,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic er, input logic eq, input logic ev, input logic es,
                     input logic el, input logic ek,
                     input logic [31:0] ea, input logic [31:0] ew);
    vec_t v;
    v.name = n; v.rst = r; v.flush = f; v.ll = l; v.ertn = e; v.klo = k;
    v.wcllb = w; v.scv = s; v.ack = a; v.addr = ad; v.wdata = wd;
    v.e_ready = er; v.e_req = eq; v.e_rv = ev; v.e_res = es; v.e_llb = el;
    v.e_klo = ek; v.e_addr = ea; v.e_wdata = ew;
    tbl.push_back(v);
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    //   name          rst fl ll er kl wc sc ak addr          wdata          rdy req rv res llb klo e_addr        e_wdata
    add("reset",        1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("idle0",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set",       0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("sc_accept",    0, 0, 0, 0, 0, 0, 1, 0, 32'h1000,     32'hDEADBEEF,  0,  1,  0, 0,  1,  0,  32'h1000,     32'hDEADBEEF);
    add("issue_hold",   0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0,  1,  0, 0,  1,  0,  32'h1000,     32'hDEADBEEF);
    add("sc_ack_ok",    0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         0,  0,  1, 1,  0,  0,  32'h0,        32'h0);
    add("back_idle",    0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("sc_fail",      0, 0, 0, 0, 0, 0, 1, 0, 32'h2000,     32'h1234,      0,  0,  1, 0,  0,  0,  32'h0,        32'h0);
    add("resp_noacc",   0, 0, 0, 0, 0, 0, 1, 0, 32'h2000,     32'h1234,      1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("idle1",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set2",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("ertn_klo1",    0, 0, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  1,  32'h0,        32'h0);
    add("klo_once",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("ertn_klo0",    0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_wcllb",     0, 0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set3",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("wcllb_clr",    0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set4",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("fl_accept",    0, 0, 0, 0, 0, 0, 1, 0, 32'h3000,     32'hCAFEF00D,  0,  1,  0, 0,  1,  0,  32'h3000,     32'hCAFEF00D);
    add("fl_issue",     0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0,  1,  0, 0,  1,  0,  32'h3000,     32'hCAFEF00D);
    add("fl_hold1",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0,  1,  0, 0,  1,  0,  32'h3000,     32'hCAFEF00D);
    add("fl_hold2",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         0,  1,  0, 0,  1,  0,  32'h3000,     32'hCAFEF00D);
    add("fl_ack",       0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set5",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("cw_accept",    0, 0, 0, 0, 0, 0, 1, 0, 32'h4000,     32'h55AA,      0,  1,  0, 0,  1,  0,  32'h4000,     32'h55AA);
    add("ack_ll_clr",   0, 0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0,         0,  0,  1, 1,  0,  0,  32'h0,        32'h0);
    add("idle2",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set6",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("rs_accept",    0, 0, 0, 0, 0, 0, 1, 0, 32'h5000,     32'h77,        0,  1,  0, 0,  1,  0,  32'h5000,     32'h77);
    add("rst_issue",    1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);
    add("ll_set7",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  1,  0,  32'h0,        32'h0);
    add("lk_accept",    0, 0, 0, 0, 0, 0, 1, 0, 32'h6000,     32'h66,        0,  1,  0, 0,  1,  0,  32'h6000,     32'h66);
    add("lk_wcllb",     0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,         0,  1,  0, 0,  0,  0,  32'h6000,     32'h66);
    add("lk_ack",       0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         0,  0,  1, 1,  0,  0,  32'h0,        32'h0);
    add("idle3",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         1,  0,  0, 0,  0,  0,  32'h0,        32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; ll_commit = tbl[i].ll;
      ertn_commit = tbl[i].ertn; llbctl_klo = tbl[i].klo; llbctl_wcllb = tbl[i].wcllb;
      sc_req_valid = tbl[i].scv; mem_ack = tbl[i].ack;
      sc_paddr = tbl[i].addr; sc_wdata = tbl[i].wdata;
      step();
      chk($sformatf("%s[%0d] ready", tbl[i].name, i), 32'(sc_req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("%s[%0d] mem_req", tbl[i].name, i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("%s[%0d] resp_valid", tbl[i].name, i), 32'(sc_resp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("%s[%0d] llbit", tbl[i].name, i), 32'(llbit), 32'(tbl[i].e_llb));
      chk($sformatf("%s[%0d] klo_clear", tbl[i].name, i), 32'(klo_clear), 32'(tbl[i].e_klo));
      if (tbl[i].e_rv || tbl[i].rst)
        chk($sformatf("%s[%0d] result", tbl[i].name, i), 32'(sc_resp_result), 32'(tbl[i].e_res));
      if (tbl[i].e_req || tbl[i].rst) begin
        chk($sformatf("%s[%0d] mem_addr", tbl[i].name, i), mem_addr, tbl[i].e_addr);
        chk($sformatf("%s[%0d] mem_wdata", tbl[i].name, i), mem_wdata, tbl[i].e_wdata);
      end
    end

    // Flush during the response cycle hides the response and returns to IDLE.
    idle_inputs();
    sc_req_valid = 1; sc_paddr = 32'h7000; sc_wdata = 32'h1;
    step();
    sc_req_valid = 0;
    chk("rflush pre resp_valid", 32'(sc_resp_valid), 32'd1);
    flush = 1;
    #1;
    chk("rflush forced resp_valid", 32'(sc_resp_valid), 32'd0);
    step();
    chk("rflush ready", 32'(sc_req_ready), 32'd1);
    chk("rflush resp_valid after", 32'(sc_resp_valid), 32'd0);

    // Flush in IDLE blocks acceptance of a simultaneous request.
    sc_req_valid = 1; flush = 1;
    step();
    chk("iflush ready", 32'(sc_req_ready), 32'd1);
    chk("iflush resp_valid", 32'(sc_resp_valid), 32'd0);
    chk("iflush mem_req", 32'(mem_req), 32'd0);
    idle_inputs();

    // Long ack latency: request held stable until ack, bounded wait for response.
    ll_commit = 1;
    step();
    ll_commit = 0; sc_req_valid = 1; sc_paddr = 32'h8000; sc_wdata = 32'hA5A5A5A5;
    step();
    sc_req_valid = 0; sc_paddr = 32'hFFFF; sc_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("long hold%0d mem_req", c), 32'(mem_req), 32'd1);
      chk($sformatf("long hold%0d mem_addr", c), mem_addr, 32'h8000);
      step();
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    begin
      int budget;
      budget = 0;
      while (!sc_resp_valid && budget < 10) begin
        step();
        budget++;
      end
      chk("long resp seen", 32'(sc_resp_valid), 32'd1);
      chk("long resp latency", 32'(budget), 32'd0);
      chk("long result", 32'(sc_resp_result), 32'd1);
      chk("long llbit", 32'(llbit), 32'd0);
    end
    step();
    chk("long ready", 32'(sc_req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule : tb_llsc_ctrl
